// File: rtl/reg_file_pkg.sv
// Shared types and default sizes for the
// multi-read-port register file.
package reg_file_pkg;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } rf_state_t;

  localparam int RF_N     = 32;
  localparam int RF_R     = 7;
  localparam int RF_NREAD = 2;

endpackage

// File: rtl/reg_file_read_port.sv
// One read port: zero-reg, bypass and
// valid masking over the storage read.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int N        = RF_N,
  parameter int R        = RF_R,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [R-1:0] addr,
  input  logic         wen,
  input  logic [R-1:0] waddr,
  input  logic [N-1:0] wdata,
  input  logic [N-1:0] mdata,
  input  logic         mvalid,
  output logic [N-1:0] data,
  output logic         valid
);

  logic is_zero;
  logic hit;

  assign is_zero = (ZERO_REG != 0) &&
                   (addr == '0);
  assign hit     = (BYPASS != 0) && wen &&
                   (waddr == addr);

  always_comb begin
    data  = '0;
    valid = 1'b0;
    if (is_zero) begin
      valid = 1'b1;
    end else if (hit) begin
      data  = wdata;
      valid = 1'b1;
    end else if (mvalid) begin
      data  = mdata;
      valid = 1'b1;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with bypass,
// valid tracking and a post-reset clear sweep.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int N        = RF_N,
  parameter int R        = RF_R,
  parameter int NREAD    = RF_NREAD,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               regWrite,
  input  logic [R-1:0]       writeReg,
  input  logic [N-1:0]       writeData,
  input  logic [NREAD*R-1:0] readReg,
  output logic [NREAD*N-1:0] readData,
  output logic [NREAD-1:0]   readValid,
  output logic               busy
);

  localparam int DEPTH = 1 << R;
  localparam logic [R-1:0] ONE  = 1;
  localparam logic [R-1:0] LAST = '1;

  rf_state_t        state;
  logic [R-1:0]     clrIdx;
  logic [DEPTH-1:0] valid;
  logic [N-1:0]     mem [DEPTH];

  logic run;
  logic wlive;
  logic wen;

  assign run   = (state == S_RUN);
  assign wlive = regWrite &&
                 !((ZERO_REG != 0) &&
                   (writeReg == '0));
  assign wen   = run && wlive;
  assign busy  = !run;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_CLEAR;
      clrIdx <= '0;
      valid  <= '0;
    end else begin
      unique case (state)
        S_CLEAR: begin
          clrIdx <= clrIdx + ONE;
          if (clrIdx == LAST) begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (wen) begin
            valid[writeReg] <= 1'b1;
          end
        end
      endcase
    end
  end

  // No per-entry reset: the sweep zeroes
  // storage; writes during reset are lost.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!run) begin
        mem[clrIdx] <= '0;
      end else if (wen) begin
        mem[writeReg] <= writeData;
      end
    end
  end

  for (genvar i = 0; i < NREAD; i++)
  begin : g_rd
    logic [R-1:0] a;
    assign a = readReg[i*R +: R];

    reg_file_read_port #(
      .N        (N),
      .R        (R),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rp (
      .addr   (a),
      .wen    (run && regWrite),
      .waddr  (writeReg),
      .wdata  (writeData),
      .mdata  (mem[a]),
      .mvalid (valid[a]),
      .data   (readData[i*N +: N]),
      .valid  (readValid[i])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench: a bypassing 4-port
// instance and a non-bypassing 2-port one.
module tb_reg_file_mp;

  localparam int N = 32;
  localparam int R = 7;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         regWrite = 1'b0;
  logic [R-1:0] writeReg = '0;
  logic [N-1:0] writeData = '0;

  logic [4*R-1:0] rra = '0;
  logic [4*N-1:0] rda;
  logic [3:0]     rva;
  logic           busya;

  logic [2*R-1:0] rrb = '0;
  logic [2*N-1:0] rdb;
  logic [1:0]     rvb;
  logic           busyb;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    int          dut;
    int          port;
    logic [N-1:0] data;
    logic        vld;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  reg_file_mp #(
    .N(N), .R(R), .NREAD(4),
    .ZERO_REG(1), .BYPASS(1)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .regWrite  (regWrite),
    .writeReg  (writeReg),
    .writeData (writeData),
    .readReg   (rra),
    .readData  (rda),
    .readValid (rva),
    .busy      (busya)
  );

  reg_file_mp #(
    .N(N), .R(R), .NREAD(2),
    .ZERO_REG(1), .BYPASS(0)
  ) u_nb (
    .clk       (clk),
    .reset     (reset),
    .regWrite  (regWrite),
    .writeReg  (writeReg),
    .writeData (writeData),
    .readReg   (rrb),
    .readData  (rdb),
    .readValid (rvb),
    .busy      (busyb)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h",
               tag, obs, exp);
    end
  endtask

  task automatic expect_rd(
    input string        tag,
    input int           dut,
    input int           port,
    input logic [N-1:0] data,
    input logic         vld
  );
    exp_t e;
    e.tag = tag;
    e.dut = dut;
    e.port = port;
    e.data = data;
    e.vld = vld;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [N-1:0] d;
    logic v;
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.dut == 0) begin
        d = rda[e.port*N +: N];
        v = rva[e.port];
      end else begin
        d = rdb[e.port*N +: N];
        v = rvb[e.port];
      end
      check(e.tag, {31'b0, v, d},
            {31'b0, e.vld, e.data});
    end
  endtask

  task automatic set_a(input logic [R-1:0] a);
    for (int p = 0; p < 4; p++)
      rra[p*R +: R] = a;
  endtask

  task automatic set_b(input logic [R-1:0] a);
    for (int p = 0; p < 2; p++)
      rrb[p*R +: R] = a;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Counts busy cycles after reset release;
  // regWrite stays high targeting entry 5.
  task automatic sweep(
    input string tag,
    input int    stop_at
  );
    int cnt;
    cnt = 0;
    reset = 1'b0;
    regWrite = 1'b1;
    writeReg = 7'd5;
    writeData = 32'hDEAD;
    while (busya && cnt < 300 &&
           (stop_at < 0 || cnt < stop_at)) begin
      cnt++;
      step();
    end
    regWrite = 1'b0;
    if (stop_at < 0) begin
      check({tag, "_busy_cnt"}, 64'(cnt),
            64'd128);
      check({tag, "_busy_b"}, 64'(busyb),
            64'd0);
    end else begin
      check({tag, "_midbusy"}, 64'(busya),
            64'd1);
    end
  endtask

  initial begin
    rra[0*R +: R] = 7'd0;
    rra[1*R +: R] = 7'd5;
    rra[2*R +: R] = 7'd64;
    rra[3*R +: R] = 7'd127;
    rrb = {7'd9, 7'd0};
    step();
    check("rst_busy", 64'(busya), 64'd1);
    expect_rd("rst_a0", 0, 0, '0, 1'b1);
    expect_rd("rst_a1", 0, 1, '0, 1'b0);
    expect_rd("rst_a2", 0, 2, '0, 1'b0);
    expect_rd("rst_a3", 0, 3, '0, 1'b0);
    expect_rd("rst_b0", 1, 0, '0, 1'b1);
    expect_rd("rst_b1", 1, 1, '0, 1'b0);
    drain();

    sweep("sw1", -1);
    set_a(7'd5);
    set_b(7'd5);
    expect_rd("dead_a", 0, 0, '0, 1'b0);
    expect_rd("dead_b", 1, 1, '0, 1'b0);
    drain();

    regWrite = 1'b1;
    writeReg = 7'd64;
    writeData = 32'h12345678;
    set_a(7'd64);
    set_b(7'd64);
    expect_rd("byp_a", 0, 0,
              32'h12345678, 1'b1);
    expect_rd("byp_b", 1, 0, '0, 1'b0);
    drain();
    step();
    regWrite = 1'b0;
    expect_rd("wr64_a", 0, 0,
              32'h12345678, 1'b1);
    expect_rd("wr64_b", 1, 0,
              32'h12345678, 1'b1);
    drain();

    regWrite = 1'b1;
    writeReg = 7'd0;
    writeData = 32'hFFFFFFFF;
    set_a(7'd0);
    set_b(7'd0);
    for (int c = 0; c < 2; c++) begin
      for (int p = 0; p < 4; p++)
        expect_rd($sformatf("z%0d_a%0d", c, p),
                  0, p, '0, 1'b1);
      for (int p = 0; p < 2; p++)
        expect_rd($sformatf("z%0d_b%0d", c, p),
                  1, p, '0, 1'b1);
      drain();
      step();
      regWrite = 1'b0;
    end

    regWrite = 1'b1;
    writeReg = 7'd102;
    writeData = 32'h66;
    step();
    regWrite = 1'b0;
    writeData = 32'h99;
    set_a(7'd102);
    set_b(7'd102);
    for (int c = 0; c < 2; c++) begin
      for (int p = 0; p < 4; p++)
        expect_rd($sformatf("e102_%0d_%0d", c, p),
                  0, p, 32'h66, 1'b1);
      expect_rd("e102_b", 1, 1, 32'h66, 1'b1);
      drain();
      step();
    end

    regWrite = 1'b1;
    writeReg = 7'd7;
    writeData = 32'hA1;
    set_a(7'd7);
    set_b(7'd7);
    expect_rd("b2b1_a", 0, 2, 32'hA1, 1'b1);
    expect_rd("b2b1_b", 1, 0, '0, 1'b0);
    drain();
    step();
    writeData = 32'hA2;
    expect_rd("b2b2_a", 0, 3, 32'hA2, 1'b1);
    expect_rd("b2b2_b", 1, 0, 32'hA1, 1'b1);
    drain();
    step();
    regWrite = 1'b0;
    expect_rd("b2b3_a", 0, 1, 32'hA2, 1'b1);
    expect_rd("b2b3_b", 1, 1, 32'hA2, 1'b1);
    drain();

    for (int i = 1; i < 64; i++) begin
      regWrite = 1'b1;
      writeReg = R'(i);
      writeData = N'(i);
      step();
    end
    regWrite = 1'b0;
    set_b(7'd40);
    expect_rd("e40_b", 1, 0, 32'd40, 1'b1);
    drain();

    reset = 1'b1;
    step();
    sweep("sw2", 40);
    reset = 1'b1;
    regWrite = 1'b1;
    writeReg = 7'd9;
    writeData = 32'h9;
    step();
    check("rst2_busy", 64'(busya), 64'd1);
    sweep("sw3", -1);

    for (int i = 1; i < 128; i += 4) begin
      for (int p = 0; p < 4; p++)
        rra[p*R +: R] = R'(i + p);
      rrb = {R'(i + 1), R'(i)};
      for (int p = 0; p < 4; p++)
        if (i + p < 128)
          expect_rd($sformatf("clr_%0d", i + p),
                    0, p, '0, 1'b0);
      expect_rd($sformatf("clrb_%0d", i),
                1, 0, '0, 1'b0);
      drain();
    end

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
